idex_pipe_stage: RTL and testbench

Parametrised ID/EX pipeline stage for the Minisys pipelined CPU. It is the successor to the fixed bank of 32-bit dff stages between decode and execute. It carries a configurable control/data payload with a valid/ready handshake and an optional skid buffer. It also supports synchronous flush for branch/jump squash and detects load-use hazards, inserting one bubble per hazard.

---
 rtl/idex_pipe_stage.sv | 108 ++++++++++
 tb/tb_idex_pipe_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/idex_pipe_stage.sv
// ID/EX pipeline stage: a main entry M drives the EX side, with an optional skid entry S.
// Includes load-use hazard detection (one bubble per hazard) and a synchronous flush.
module idex_pipe_stage #(
  parameter int PAYLOAD_W = 138,
  parameter int REG_AW    = 5,
  parameter int SKID      = 1
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] payload_d,
  input  logic [REG_AW-1:0]    rs_d,
  input  logic [REG_AW-1:0]    rt_d,
  input  logic [REG_AW-1:0]    wn_d,
  input  logic                 regwrite_d,
  input  logic                 memread_d,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] payload_e,
  output logic [REG_AW-1:0]    wn_e,
  output logic                 regwrite_e,
  output logic                 memread_e,
  output logic                 load_use_stall
);

  localparam bit USE_SKID = (SKID != 0);

  logic                 m_valid, m_regwrite, m_memread;
  logic [PAYLOAD_W-1:0] m_payload;
  logic [REG_AW-1:0]    m_wn;
  logic                 s_valid, s_regwrite, s_memread;
  logic [PAYLOAD_W-1:0] s_payload;
  logic [REG_AW-1:0]    s_wn;

  logic hz_m, hz_s, m_free, accept;

  // A held load whose destination (other than $zero) matches a source of the ID instruction.
  assign hz_m = m_valid && m_memread && (m_wn != '0) && ((m_wn == rs_d) || (m_wn == rt_d));
  assign hz_s = USE_SKID && s_valid && s_memread && (s_wn != '0) &&
                ((s_wn == rs_d) || (s_wn == rt_d));
  assign load_use_stall = in_valid && (hz_m || hz_s);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready. With the skid entry, ready depends only on registered
  // S occupancy plus flush/hazard, which breaks the combinational path from out_ready.
  assign m_free   = !m_valid || out_ready;
  assign in_ready = USE_SKID ? (!s_valid && !flush && !load_use_stall)
                             : (m_free && !flush && !load_use_stall);
  assign accept   = in_valid && in_ready;

  assign out_valid  = m_valid;
  assign payload_e  = m_payload;
  assign wn_e       = m_wn;
  assign regwrite_e = m_valid && m_regwrite;
  assign memread_e  = m_valid && m_memread;

  // Occupancy: flush wins over drain and accept.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_free) begin
      m_valid <= s_valid || accept;
      s_valid <= 1'b0;
    end else if (accept) begin
      s_valid <= 1'b1;
    end
  end

  // Contents are not cleared on drain or flush; only the valid bits qualify them.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_payload  <= '0;
      m_wn       <= '0;
      m_regwrite <= 1'b0;
      m_memread  <= 1'b0;
      s_payload  <= '0;
      s_wn       <= '0;
      s_regwrite <= 1'b0;
      s_memread  <= 1'b0;
    end else if (!flush) begin
      if (m_free) begin
        if (s_valid) begin
          m_payload  <= s_payload;
          m_wn       <= s_wn;
          m_regwrite <= s_regwrite;
          m_memread  <= s_memread;
        end else if (accept) begin
          m_payload  <= payload_d;
          m_wn       <= wn_d;
          m_regwrite <= regwrite_d;
          m_memread  <= memread_d;
        end
      end else if (accept) begin
        s_payload  <= payload_d;
        s_wn       <= wn_d;
        s_regwrite <= regwrite_d;
        s_memread  <= memread_d;
      end
    end
  end

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Directed bench for idex_pipe_stage (SKID=1): streaming, backpressure, load-use bubble,
// $zero/no-match hazards, flush with held data, and asynchronous reset mid-stream.
module tb_idex_pipe_stage;

  localparam int PW = 138;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          clrn;
  logic          in_valid, in_ready;
  logic [PW-1:0] payload_d, payload_e;
  logic [AW-1:0] rs_d, rt_d, wn_d, wn_e;
  logic          regwrite_d, memread_d, flush;
  logic          out_valid, out_ready, regwrite_e, memread_e, load_use_stall;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0] exp_q[$];

  idex_pipe_stage #(.PAYLOAD_W(PW), .REG_AW(AW), .SKID(1)) dut (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
    .payload_d(payload_d), .rs_d(rs_d), .rt_d(rt_d), .wn_d(wn_d),
    .regwrite_d(regwrite_d), .memread_d(memread_d), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .payload_e(payload_e),
    .wn_e(wn_e), .regwrite_e(regwrite_e), .memread_e(memread_e),
    .load_use_stall(load_use_stall)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop on every EX-side transfer
  always @(negedge clk) begin
    if (clrn && out_valid && out_ready) begin
      chk("sb_nonempty", PW'(exp_q.size() != 0), PW'(1));
      if (exp_q.size() != 0) chk("sb_payload", payload_e, exp_q.pop_front());
    end
  end

  // driver: one cycle of ID-side stimulus with hand-derived in_ready/stall/out_valid
  task automatic step(input logic iv, input logic [15:0] tag,
                      input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] wn,
                      input logic rw, input logic mr, input logic ordy, input logic fl,
                      input logic exp_rdy, input logic exp_stall, input logic exp_ov);
    logic [PW-1:0] p;
    p = '0;
    p[15:0] = tag;
    p[PW-1 -: 32] = $urandom;
    in_valid = iv; payload_d = p; rs_d = rs; rt_d = rt; wn_d = wn;
    regwrite_d = rw; memread_d = mr; out_ready = ordy; flush = fl;
    @(negedge clk);
    chk($sformatf("in_ready_%0h", tag), PW'(in_ready), PW'(exp_rdy));
    chk($sformatf("stall_%0h", tag), PW'(load_use_stall), PW'(exp_stall));
    chk($sformatf("out_valid_%0h", tag), PW'(out_valid), PW'(exp_ov));
    if (iv && exp_rdy) exp_q.push_back(p);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input logic exp_ov);
    step(1'b0, 16'h0, '0, '0, '0, 1'b0, 1'b0, ordy, 1'b0, 1'b1, 1'b0, exp_ov);
  endtask

  initial begin
    clrn = 1'b0; in_valid = 1'b0; payload_d = '0; rs_d = '0; rt_d = '0; wn_d = '0;
    regwrite_d = 1'b0; memread_d = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_regwrite", PW'(regwrite_e), PW'(0));
    chk("rst_memread", PW'(memread_e), PW'(0));
    chk("rst_stall", PW'(load_use_stall), PW'(0));
    chk("rst_payload", payload_e, '0);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // back-to-back stream
    step(1'b1, 16'h1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stream_regwrite", PW'(regwrite_e), PW'(1));
    chk("stream_wn", PW'(wn_e), PW'(3));
    step(1'b1, 16'h2, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h3, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    // backpressure into the skid entry
    step(1'b1, 16'hA, '0, '0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'hB, '0, '0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'hC, '0, '0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'hC, '0, '0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'hC, '0, '0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b1);

    // load-use: lw $5 then add using $5 -> one stall cycle, one bubble
    step(1'b1, 16'h10, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h11, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'h11, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1);

    // no false hazards: load to $zero, and a load to $5 followed by $6/$7 sources
    step(1'b1, 16'h20, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h21, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h22, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h23, 5'd6, 5'd7, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b1);

    // flush with M and S both valid, alongside a new input
    step(1'b1, 16'h30, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h31, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 16'h32, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_q.delete();
    chk("flush_out_valid", PW'(out_valid), PW'(0));
    chk("flush_regwrite", PW'(regwrite_e), PW'(0));
    chk("flush_memread", PW'(memread_e), PW'(0));
    idle(1'b1, 1'b0);

    // asynchronous reset between edges
    step(1'b1, 16'h40, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    chk("pre_arst_out_valid", PW'(out_valid), PW'(1));
    chk("pre_arst_memread", PW'(memread_e), PW'(1));
    clrn = 1'b0;
    #1;
    chk("arst_out_valid", PW'(out_valid), PW'(0));
    chk("arst_regwrite", PW'(regwrite_e), PW'(0));
    chk("arst_memread", PW'(memread_e), PW'(0));
    exp_q.delete();
    #1;
    clrn = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h50, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);

    chk("sb_drained", PW'(exp_q.size()), PW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
